tx_gearbox_66b32b: RTL and testbench

- Sits directly downstream of the xgmii_encoder and directly upstream of the SerDes TX data port.
- Consumes 32-bit encoded payload words plus a 2-bit sync header, one 66b block per two accepted words.
- Emits a continuous 32-bit serial-order stream at the same clock rate.
- Throttles the encoder via a pause output: 2 of every 66 cycles, so 32 blocks (2112 bits) fit in 66 output words.

---
 rtl/tx_gearbox_66b32b_if.sv | 30 +++
 rtl/tx_gearbox_66b32b.sv | 143 ++++++++++++++
 tb/tb_tx_gearbox_66b32b.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_gearbox_66b32b_if.sv
// tx_gearbox_66b32b_if: encoder-facing word/header bus and serial-side outputs of the 66b->32b gearbox.
// master = encoder/driver side, slave = gearbox side.
interface tx_gearbox_66b32b_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned HDR_WIDTH  = 2
);

   logic [DATA_WIDTH-1:0] i_encoded_data;
   logic [HDR_WIDTH-1:0]  i_sync_hdr;
   logic                  o_xgmii_pause;
   logic [DATA_WIDTH-1:0] o_tx_data;
   logic                  o_hdr_err;

   modport master (
      output i_encoded_data,
      output i_sync_hdr,
      input  o_xgmii_pause,
      input  o_tx_data,
      input  o_hdr_err
   );

   modport slave (
      input  i_encoded_data,
      input  i_sync_hdr,
      output o_xgmii_pause,
      output o_tx_data,
      output o_hdr_err
   );

endinterface

// File: rtl/tx_gearbox_66b32b.sv
// tx_gearbox_66b32b: packs 2-bit sync header + 2x32-bit payload blocks into a continuous
// 32-bit stream (bit 0 first). A free-running 0..65 counter pauses the encoder for two
// cycles per sequence, during which the 64-bit residual drains.
// Optional: define TX_SCRAMBLER_EN to scramble the payload with x^58 + x^39 + 1.
module tx_gearbox_66b32b #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned HDR_WIDTH    = 2,
   parameter int unsigned PAUSE_PERIOD = 66
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   tx_gearbox_66b32b_if.slave    bus
);

   localparam int unsigned NEW_W = DATA_WIDTH + HDR_WIDTH;        // bits entering per header word
   localparam int unsigned RES_W = 2 * DATA_WIDTH;                // max residual
   localparam int unsigned BUF_W = RES_W + NEW_W;                 // shift datapath
   localparam int unsigned TOP_W = BUF_W - DATA_WIDTH - RES_W;    // never-set guard bits
   localparam int unsigned CNT_W = $clog2(PAUSE_PERIOD);
   localparam int unsigned LEN_W = $clog2(BUF_W);

   typedef enum logic {
      PH_HDR  = 1'b0,
      PH_DATA = 1'b1
   } phase_e;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   phase_e                phase_q, phase_d;
   logic [RES_W-1:0]      res_q, res_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  hdr_err_q, hdr_err_d;

   logic                  pause_c;
   logic [DATA_WIDTH-1:0] payload_c;
   logic [NEW_W-1:0]      new_bits;
   logic [LEN_W-1:0]      new_len;
   logic [BUF_W-1:0]      buf_w;
   logic                  unused_top_bits;

   // Pause is decoded straight from the counter so upstream sees it in the same cycle
   assign pause_c = (cnt_q >= CNT_W'(PAUSE_PERIOD - 2));

`ifdef TX_SCRAMBLER_EN
   localparam int unsigned SCR_W = 58;
   localparam int unsigned TAP_A = 38;   // x^39 term
   localparam int unsigned TAP_B = 57;   // x^58 term

   logic [SCR_W-1:0] scr_q, scr_d;
   logic [SCR_W-1:0] scr_s;

   // Self-synchronizing scrambler, LSB first; state only advances on accepted words
   always_comb begin
      scr_d     = scr_q;
      scr_s     = scr_q;
      payload_c = bus.i_encoded_data;
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         payload_c[i] = bus.i_encoded_data[i] ^ scr_s[TAP_A] ^ scr_s[TAP_B];
         scr_s        = {scr_s[SCR_W-2:0], payload_c[i]};
      end
      if (!pause_c) begin
         scr_d = scr_s;
      end
   end

   // Scrambler state register, seeded to all ones
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         scr_q <= '1;
      end else begin
         scr_q <= scr_d;
      end
   end
`else
   assign payload_c = bus.i_encoded_data;
`endif

   // Sequence counter, block phase and residual shift buffer next-state
   always_comb begin
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      res_d     = res_q;
      len_d     = len_q;
      tx_data_d = '0;
      hdr_err_d = 1'b0;
      new_bits  = '0;
      new_len   = '0;
      buf_w     = '0;

      cnt_d = (cnt_q == CNT_W'(PAUSE_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);

      if (!pause_c) begin
         case (phase_q)
            PH_HDR: begin
               // Header goes out first (hdr[0] then hdr[1]), payload follows LSB first
               new_bits  = {payload_c, bus.i_sync_hdr};
               new_len   = LEN_W'(NEW_W);
               hdr_err_d = (bus.i_sync_hdr == {HDR_WIDTH{1'b0}}) ||
                           (bus.i_sync_hdr == {HDR_WIDTH{1'b1}});
               phase_d   = PH_DATA;
            end
            default: begin
               new_bits  = NEW_W'(payload_c);
               new_len   = LEN_W'(DATA_WIDTH);
               phase_d   = PH_HDR;
            end
         endcase
      end

      // New bits land just above the residual; lowest word leaves, the rest stays
      buf_w     = BUF_W'(res_q) | (BUF_W'(new_bits) << len_q);
      tx_data_d = buf_w[DATA_WIDTH-1:0];
      res_d     = buf_w[DATA_WIDTH +: RES_W];
      len_d     = len_q + new_len - LEN_W'(DATA_WIDTH);
   end

   // Top guard bits of the datapath are never populated (residual peaks at 64)
   assign unused_top_bits = ^buf_w[BUF_W-1 -: TOP_W];

   // State and output registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q     <= '0;
         phase_q   <= PH_HDR;
         res_q     <= '0;
         len_q     <= '0;
         tx_data_q <= '0;
         hdr_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         res_q     <= res_d;
         len_q     <= len_d;
         tx_data_q <= tx_data_d;
         hdr_err_q <= hdr_err_d;
      end
   end

   assign bus.o_xgmii_pause = pause_c;
   assign bus.o_tx_data     = tx_data_q;
   assign bus.o_hdr_err     = hdr_err_q;

endmodule

// File: tb/tb_tx_gearbox_66b32b.sv
// tb_tx_gearbox_66b32b: table vectors, directed corner sequences and a random stream
// checked against a bit-queue model of the gearbox (and scrambler when TX_SCRAMBLER_EN).
module tb_tx_gearbox_66b32b;

   logic i_clk     = 1'b0;
   logic i_reset_n = 1'b0;

   tx_gearbox_66b32b_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

   tx_gearbox_66b32b dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: serial bit queue, word parity and cycle count since reset
   int unsigned mcnt;
   bit          mphase;
   bit          bitq[$];
   logic [31:0] m_tx;
   logic        m_err;
`ifdef TX_SCRAMBLER_EN
   bit          hist[$];   // last 58 scrambled bits, oldest first
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  hdr;
      logic [31:0] exp_tx;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];
   int   exp_p[6] = '{64, 65, 130, 131, 196, 197};
   int   pq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit scr_bit(input bit d);
`ifdef TX_SCRAMBLER_EN
      bit s;
      s = d ^ hist[19] ^ hist[0];   // bits sent 39 and 58 positions ago
      hist.push_back(s);
      void'(hist.pop_front());
      return s;
`else
      return d;
`endif
   endfunction

   function automatic void model_reset();
      mcnt   = 0;
      mphase = 1'b0;
      bitq.delete();
      m_tx   = '0;
      m_err  = 1'b0;
`ifdef TX_SCRAMBLER_EN
      hist.delete();
      for (int i = 0; i < 58; i++) hist.push_back(1'b1);
`endif
   endfunction

   // One clock: drive inputs, check pause, advance the model, check the registered outputs
   task automatic step(input logic [31:0] d, input logic [1:0] h, output bit acc);
      bit          p;
      logic [31:0] t;
      bus.i_encoded_data = d;
      bus.i_sync_hdr     = h;
      p = (mcnt % 66) >= 64;
      check("pause", 32'(bus.o_xgmii_pause), 32'(p));
      acc   = !p;
      m_err = 1'b0;
      if (!p) begin
         if (!mphase) begin
            bitq.push_back(h[0]);
            bitq.push_back(h[1]);
            m_err = (h == 2'b00) || (h == 2'b11);
         end
         for (int i = 0; i < 32; i++) bitq.push_back(scr_bit(d[i]));
         mphase = !mphase;
      end
      t = '0;
      for (int i = 0; i < 32; i++) if (bitq.size() > 0) t[i] = bitq.pop_front();
      m_tx = t;
      mcnt++;
      @(posedge i_clk);
      #1;
      check("model_tx", bus.o_tx_data, m_tx);
      check("model_hdr_err", 32'(bus.o_hdr_err), 32'(m_err));
   endtask

   task automatic do_reset();
      i_reset_n          = 1'b0;
      bus.i_encoded_data = '0;
      bus.i_sync_hdr     = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_tx", bus.o_tx_data, 32'h0);
      check("rst_hdr_err", 32'(bus.o_hdr_err), 32'h0);
      check("rst_pause", 32'(bus.o_xgmii_pause), 32'h0);
      i_reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          found;
      int          k;
      int          words;
      int          guard;
      int unsigned start_cnt;
      logic [1:0]  h;

      vecs[0] = '{32'h0403_0201, 2'b01, 32'h100C_0805, 1'b0};
      vecs[1] = '{32'h0807_0605, 2'b11, 32'h201C_1814, 1'b0};   // phase 1: header ignored
      vecs[2] = '{32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFC, 1'b1};
      vecs[3] = '{32'h0000_0000, 2'b00, 32'h0000_000F, 1'b0};
      vecs[4] = '{32'h1234_5678, 2'b00, 32'h8D15_9E00, 1'b1};
      vecs[5] = '{32'hA5A5_A5A5, 2'b10, 32'h6969_6944, 1'b0};
      vecs[6] = '{32'h0000_0000, 2'b01, 32'h0000_0069, 1'b0};

      // Table vectors from reset
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].data, vecs[i].hdr, acc);
`ifndef TX_SCRAMBLER_EN
         check($sformatf("vec%0d_tx", i), bus.o_tx_data, vecs[i].exp_tx);
`endif
         check($sformatf("vec%0d_hdr_err", i), 32'(bus.o_hdr_err), 32'(vecs[i].exp_err));
      end

      // Header error: single-cycle pulse, header bits still transmitted
      do_reset();
      step($urandom, 2'b11, acc);
      check("hdrerr_pulse", 32'(bus.o_hdr_err), 32'h1);
      check("hdrerr_bits", 32'(bus.o_tx_data[1:0]), 32'h3);
      step($urandom, 2'b11, acc);
      check("hdrerr_clear", 32'(bus.o_hdr_err), 32'h0);
      step($urandom, 2'b01, acc);
      check("hdrerr_ok_hdr", 32'(bus.o_hdr_err), 32'h0);

      // Residual drain over the two pause cycles
      do_reset();
      for (int i = 0; i < 64; i++) step(32'hFFFF_FFFF, 2'b10, acc);
      for (int i = 0; i < 2; i++) begin
         step(32'h0, 2'b01, acc);
`ifndef TX_SCRAMBLER_EN
         check($sformatf("drain_word%0d", i), bus.o_tx_data, 32'hFFFF_FFFF);
`endif
      end
      step(32'h0, 2'b01, acc);
      check("drain_next_hdr", 32'(bus.o_tx_data[1:0]), 32'h1);

      // Pause cadence over 200 cycles
      do_reset();
      pq.delete();
      for (int c = 0; c < 200; c++) begin
         if (bus.o_xgmii_pause === 1'b1) pq.push_back(c);
         step($urandom, 2'($urandom_range(0, 3)), acc);
      end
      check("pause_count", 32'(pq.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("pause_cycle%0d", i), (i < pq.size()) ? 32'(pq[i]) : 32'hFFFF_FFFF, 32'(exp_p[i]));

      // Reset mid-sequence at cnt 30
      do_reset();
      for (int c = 0; c < 30; c++) step($urandom, 2'($urandom_range(0, 3)), acc);
      i_reset_n = 1'b0;
      #1;
      check("midrst_tx_async", bus.o_tx_data, 32'h0);
      check("midrst_pause_async", 32'(bus.o_xgmii_pause), 32'h0);
      do_reset();
      step(32'h0403_0201, 2'b01, acc);
`ifndef TX_SCRAMBLER_EN
      check("midrst_first_word", bus.o_tx_data, 32'h100C_0805);
`endif
      check("midrst_first_hdr", 32'(bus.o_tx_data[1:0]), 32'h1);
      found = -1;
      k     = 1;
      while (found < 0 && k < 100) begin
         if (bus.o_xgmii_pause === 1'b1) found = k;
         else begin
            step($urandom, 2'b10, acc);
            k++;
         end
      end
      check("midrst_first_pause", 32'(found), 32'd64);

      // Random stream of 1000 blocks against the model
      do_reset();
      words = 0;
      guard = 0;
      while (words < 2000 && guard < 5000) begin
         start_cnt = mcnt % 66;
         h         = 2'($urandom_range(0, 3));
         step($urandom, h, acc);
         if (acc) words++;
         if (start_cnt == 0) check("rand_hdr_clear", 32'(bus.o_tx_data[1:0]), 32'(h));
         guard++;
      end
      check("rand_words", 32'(words), 32'd2000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
